// File: rtl/nw_fill_controller.sv
// Needleman-Wunsch matrix fill sequencer: walks (1,1)..(N,N), fetches neighbours, scores and writes back.
// Optional local-alignment (Smith-Waterman) mode selected by defining SMITH_WATERMAN_EN.
module nw_fill_controller #(
  parameter int unsigned       N        = 128,
  parameter int unsigned       BitAddr  = $clog2(N + 1),
  parameter logic signed [8:0] MATCH    = 9'sd1,
  parameter logic signed [8:0] MISMATCH = -9'sd1,
  parameter logic signed [8:0] GAP      = -9'sd2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           char_a,
  input  logic [1:0]           char_b,
  input  logic                 signal,
  input  logic signed [8:0]    diag,
  input  logic signed [8:0]    up,
  input  logic signed [8:0]    left,
  output logic [BitAddr:0]     i,
  output logic [BitAddr:0]     j,
  output logic                 en_read,
  output logic                 en_ins,
  output logic                 we,
  output logic signed [8:0]    max,
  output logic [1:0]           dir,
  output logic                 dir_we,
  output logic                 busy,
  output logic                 done,
`ifdef SMITH_WATERMAN_EN
  output logic signed [8:0]    best_score,
  output logic [BitAddr:0]     best_i,
  output logic [BitAddr:0]     best_j,
`endif
  output logic signed [8:0]    final_score
);

  localparam int unsigned IW = BitAddr + 1;
  localparam int unsigned SW = 9;
  localparam int unsigned EW = SW + 1;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
`ifdef SMITH_WATERMAN_EN
  localparam logic [1:0] DIR_STOP = 2'b11;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        i_q, j_q;
  logic signed [SW-1:0] diag_q, up_q, left_q;
  logic signed [SW-1:0] max_q, final_q;
  logic [1:0]           dir_q;
  logic                 en_read_q, en_ins_q, we_q, dir_we_q, busy_q, done_q;

  logic signed [SW-1:0] bonus_d;
  logic signed [EW-1:0] sum_d_d, sum_u_d, sum_l_d;
  logic signed [SW-1:0] s_d_d, s_u_d, s_l_d;
  logic signed [SW-1:0] max_d;
  logic [1:0]           dir_d;

  // Widen to 10 bits, then clamp back into the 9-bit signed score range.
  function automatic logic signed [SW-1:0] sat9(input logic signed [EW-1:0] x);
    if (x > 10'sd255) begin
      return 9'sd255;
    end else if (x < -10'sd256) begin
      return -9'sd256;
    end else begin
      return x[SW-1:0];
    end
  endfunction

  // Candidate scores and best-move selection; ties resolve diag > up > left.
  always_comb begin
    bonus_d = (char_a == char_b) ? MATCH : MISMATCH;
    sum_d_d = $signed({diag_q[SW-1], diag_q}) + $signed({bonus_d[SW-1], bonus_d});
    sum_u_d = $signed({up_q[SW-1], up_q})     + $signed({GAP[SW-1], GAP});
    sum_l_d = $signed({left_q[SW-1], left_q}) + $signed({GAP[SW-1], GAP});
    s_d_d   = sat9(sum_d_d);
    s_u_d   = sat9(sum_u_d);
    s_l_d   = sat9(sum_l_d);
    max_d   = s_d_d;
    dir_d   = DIR_DIAG;
    if (s_d_d >= s_u_d && s_d_d >= s_l_d) begin
      max_d = s_d_d;
      dir_d = DIR_DIAG;
    end else if (s_u_d >= s_l_d) begin
      max_d = s_u_d;
      dir_d = DIR_UP;
    end else begin
      max_d = s_l_d;
      dir_d = DIR_LEFT;
    end
`ifdef SMITH_WATERMAN_EN
    if (max_d <= 9'sd0) begin
      max_d = 9'sd0;
      dir_d = DIR_STOP;
    end
`endif
  end

`ifdef SMITH_WATERMAN_EN
  logic signed [SW-1:0] best_score_q;
  logic [IW-1:0]        best_i_q, best_j_q;
`endif

  // Fill sequencer with registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      diag_q    <= '0;
      up_q      <= '0;
      left_q    <= '0;
      max_q     <= '0;
      final_q   <= '0;
      dir_q     <= DIR_DIAG;
      en_read_q <= 1'b0;
      en_ins_q  <= 1'b0;
      we_q      <= 1'b0;
      dir_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SMITH_WATERMAN_EN
      best_score_q <= '0;
      best_i_q     <= '0;
      best_j_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            i_q       <= IW'(1);
            j_q       <= IW'(1);
            busy_q    <= 1'b1;
            en_read_q <= 1'b1;
            state_q   <= S_READ;
`ifdef SMITH_WATERMAN_EN
            best_score_q <= '0;
            best_i_q     <= '0;
            best_j_q     <= '0;
`endif
          end
        end
        S_READ: begin
          if (signal) begin
            diag_q    <= diag;
            up_q      <= up;
            left_q    <= left;
            en_read_q <= 1'b0;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          max_q    <= max_d;
          dir_q    <= dir_d;
          en_ins_q <= 1'b1;
          we_q     <= 1'b1;
          dir_we_q <= 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          en_ins_q <= 1'b0;
          we_q     <= 1'b0;
          dir_we_q <= 1'b0;
          state_q  <= S_NEXT;
`ifdef SMITH_WATERMAN_EN
          // Strictly greater keeps the first occurrence on ties.
          if (max_q > best_score_q) begin
            best_score_q <= max_q;
            best_i_q     <= i_q;
            best_j_q     <= j_q;
          end
`endif
        end
        S_NEXT: begin
          if (j_q < IW'(N)) begin
            j_q       <= j_q + IW'(1);
            en_read_q <= 1'b1;
            state_q   <= S_READ;
          end else if (i_q < IW'(N)) begin
            i_q       <= i_q + IW'(1);
            j_q       <= IW'(1);
            en_read_q <= 1'b1;
            state_q   <= S_READ;
          end else begin
`ifdef SMITH_WATERMAN_EN
            final_q <= best_score_q;
`else
            final_q <= max_q;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i           = i_q;
  assign j           = j_q;
  assign en_read     = en_read_q;
  assign en_ins      = en_ins_q;
  assign we          = we_q;
  assign max         = max_q;
  assign dir         = dir_q;
  assign dir_we      = dir_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_score = final_q;
`ifdef SMITH_WATERMAN_EN
  assign best_score  = best_score_q;
  assign best_i      = best_i_q;
  assign best_j      = best_j_q;
`endif

endmodule

// File: tb/tb_nw_fill_controller.sv
// Directed bench for nw_fill_controller at N=2 with a small behavioural score-RAM responder.
module tb_nw_fill_controller;

  localparam int unsigned N  = 2;
  localparam int unsigned BA = $clog2(N + 1);
  localparam int unsigned IW = BA + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [1:0]           char_a, char_b;
  logic                 signal = 1'b0;
  logic signed [8:0]    diag = '0, up = '0, left = '0;
  logic [IW-1:0]        i, j;
  logic                 en_read, en_ins, we, dir_we, busy, done;
  logic signed [8:0]    max, final_score;
  logic [1:0]           dir;
`ifdef SMITH_WATERMAN_EN
  logic signed [8:0]    best_score;
  logic [IW-1:0]        best_i, best_j;
`endif

  nw_fill_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .char_a(char_a), .char_b(char_b),
    .signal(signal), .diag(diag), .up(up), .left(left), .i(i), .j(j),
    .en_read(en_read), .en_ins(en_ins), .we(we), .max(max), .dir(dir),
    .dir_we(dir_we), .busy(busy), .done(done),
`ifdef SMITH_WATERMAN_EN
    .best_score(best_score), .best_i(best_i), .best_j(best_j),
`endif
    .final_score(final_score)
  );

  always #5 clk = ~clk;

  logic [1:0] seq_a [0:N-1];
  logic [1:0] seq_b [0:N-1];
  int mtx [0:N][0:N];

  always_comb char_a = (i >= IW'(1) && i <= IW'(N)) ? seq_a[int'(i) - 1] : 2'd0;
  always_comb char_b = (j >= IW'(1) && j <= IW'(N)) ? seq_b[int'(j) - 1] : 2'd0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Responder knobs and observations
  int ov_en = 0, ov_d = 0, ov_u = 0, ov_l = 0;
  int dly12 = 0;
  int rd_cnt = 0, ri = 0, rj = 0, moved = 0;
  int len12 = 0, moved12 = 0;

  // Score-RAM responder: answers en_read after an optional delay.
  initial begin
    forever begin
      @(negedge clk);
      if (en_read) begin
        rd_cnt++;
        if (rd_cnt == 1) begin
          ri = int'(i);
          rj = int'(j);
        end else if (int'(i) != ri || int'(j) != rj) begin
          moved++;
        end
        if (rd_cnt > ((ri == 1 && rj == 2) ? dly12 : 0)) begin
          signal = 1'b1;
          if (ov_en != 0) begin
            diag = 9'(ov_d); up = 9'(ov_u); left = 9'(ov_l);
          end else begin
            diag = 9'(mtx[ri-1][rj-1]); up = 9'(mtx[ri-1][rj]); left = 9'(mtx[ri][rj-1]);
          end
        end else begin
          signal = 1'b0;
        end
      end else begin
        if (rd_cnt != 0 && ri == 1 && rj == 2) begin
          len12   = rd_cnt;
          moved12 = moved;
        end
        rd_cnt = 0;
        moved  = 0;
        signal = 1'b0;
      end
    end
  end

  int wr_n = 0, done_cnt = 0, strobe_err = 0, done_busy_err = 0;
  int wr_i [0:15], wr_j [0:15], wr_max [0:15], wr_dir [0:15];

  // Write-back logger
  initial begin
    forever begin
      @(negedge clk);
      if (we !== dir_we || we !== en_ins) strobe_err++;
      if (done && busy) done_busy_err++;
      if (done) done_cnt++;
      if (we) begin
        if (wr_n < 16) begin
          wr_i[wr_n] = int'(i); wr_j[wr_n] = int'(j);
          wr_max[wr_n] = int'(max); wr_dir[wr_n] = int'(dir);
        end
        if (int'(i) <= N && int'(j) <= N) mtx[int'(i)][int'(j)] = int'(max);
        wr_n++;
      end
    end
  end

  task automatic init_mtx(input int border_step);
    for (int r = 0; r <= N; r++)
      for (int c = 0; c <= N; c++)
        mtx[r][c] = (r == 0) ? -border_step * c : ((c == 0) ? -border_step * r : 0);
  endtask

  task automatic set_seq(input logic [1:0] a0, input logic [1:0] a1,
                         input logic [1:0] b0, input logic [1:0] b1);
    seq_a[0] = a0; seq_a[1] = a1; seq_b[0] = b0; seq_b[1] = b1;
  endtask

  task automatic run_fill(input string tag, input int inject_start);
    int seen;
    int injected;
    seen = 0;
    injected = 0;
    wr_n = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 400 && seen == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject_start != 0 && wr_n == 1 && injected == 0) begin
        start = 1'b1;
        injected = 1;
      end
      if (done_cnt > 0) seen = 1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_finished"}, seen, 1);
  endtask

`ifndef SMITH_WATERMAN_EN
  int exp_max [0:3] = '{1, -1, -1, 2};
  int exp_dir [0:3] = '{0, 2, 1, 0};
  int exp_i   [0:3] = '{1, 1, 2, 2};
  int exp_j   [0:3] = '{1, 2, 1, 2};
`endif

  initial begin
    set_seq(2'd0, 2'd1, 2'd0, 2'd1);
    init_mtx(2);
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({i, j, max, dir, en_read, en_ins, we, dir_we, busy, done, final_score}), 0);
    rst = 1'b1;
    @(negedge clk);

`ifndef SMITH_WATERMAN_EN
    // Reference fill A=B=(0,1)
    run_fill("basic", 0);
    check("basic_writes", wr_n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_max%0d", k), wr_max[k], exp_max[k]);
      check($sformatf("basic_dir%0d", k), wr_dir[k], exp_dir[k]);
      check($sformatf("basic_ij%0d", k), wr_i[k] * 10 + wr_j[k], exp_i[k] * 10 + exp_j[k]);
    end
    check("basic_done_cnt", done_cnt, 1);
    check("basic_final", int'(final_score), 2);
    check("basic_end_ij", int'(i) * 10 + int'(j), 22);
    check("basic_busy_after", int'(busy), 0);

    // Tie resolution, with a stray start mid-fill that must be ignored
    set_seq(2'd0, 2'd1, 2'd2, 2'd3);
    ov_en = 1; ov_d = 0; ov_u = 1; ov_l = 1;
    run_fill("tie", 1);
    check("tie_writes", wr_n, 4);
    check("tie_max", wr_max[0], -1);
    check("tie_dir", wr_dir[0], 0);
    check("tie_done_cnt", done_cnt, 1);

    // Negative saturation
    ov_d = -256; ov_u = -256; ov_l = -256;
    run_fill("satlo", 0);
    check("satlo_max", wr_max[0], -256);
    check("satlo_dir", wr_dir[0], 0);
    check("satlo_final", int'(final_score), -256);

    // Positive saturation on match, no clamp on mismatch
    set_seq(2'd0, 2'd1, 2'd0, 2'd1);
    ov_d = 255; ov_u = 0; ov_l = 0;
    run_fill("sathi", 0);
    check("sathi_max11", wr_max[0], 255);
    check("sathi_max12", wr_max[1], 254);
    ov_en = 0;

    // Delayed neighbour read on (1,2)
    init_mtx(2);
    dly12 = 5;
    run_fill("delay", 0);
    dly12 = 0;
    check("delay_en_read_len", len12, 6);
    check("delay_ij_moved", moved12, 0);
    check("delay_max12", wr_max[1], -1);
    check("delay_final", int'(final_score), 2);

    // Asynchronous abort during write of (1,2), then restart
    init_mtx(2);
    wr_n = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (we && i == IW'(1) && j == IW'(2)) break;
    end
    check("abort_reached_write", int'(we && i == IW'(1) && j == IW'(2)), 1);
    #1 rst = 1'b0;
    #1;
    check("abort_outputs", int'({i, j, max, dir, en_read, en_ins, we, dir_we, busy, done, final_score}), 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    init_mtx(2);
    run_fill("restart", 0);
    check("restart_first_ij", wr_i[0] * 10 + wr_j[0], 11);
    check("restart_first_max", wr_max[0], 1);
    check("restart_final", int'(final_score), 2);
    check("restart_done_cnt", done_cnt, 1);
`else
    // Local alignment: no positive cell anywhere
    set_seq(2'd0, 2'd1, 2'd2, 2'd3);
    init_mtx(0);
    run_fill("sw", 0);
    check("sw_writes", wr_n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_max%0d", k), wr_max[k], 0);
      check($sformatf("sw_dir%0d", k), wr_dir[k], 3);
    end
    check("sw_best_score", int'(best_score), 0);
    check("sw_best_ij", int'(best_i) * 10 + int'(best_j), 0);
    check("sw_final", int'(final_score), 0);
`endif

    check("strobes_coincident", strobe_err, 0);
    check("done_without_busy", done_busy_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
